res_acc: RTL and testbench

RES_ACC -- requirements
Module: res_acc

---
 rtl/res_acc.sv | 76 +++++++
 tb/tb_res_acc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_acc.sv
// Window accumulator: sums N unsigned 9-bit results and presents the
// window sum and truncated mean through a valid/ready output handshake.
module res_acc #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  din,
  input  logic        din_vld,
  output logic        din_rdy,
  input  logic        clr,
  output logic [12:0] out_sum,
  output logic [8:0]  out_avg,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [4:0]  cnt
);

  localparam int LOG2N = (N == 16) ? 4 :
                         (N == 8)  ? 3 :
                         (N == 4)  ? 2 : 1;

  localparam logic [4:0] LAST = 5'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [12:0] acc;
  logic [12:0] sum_nxt;
  logic        take;

  assign din_rdy = (state != HOLD);
  assign out_vld = (state == HOLD);
  assign sum_nxt = acc + {4'd0, din};
  assign take    = din_vld & din_rdy & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_avg <= '0;
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (clr) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (take) begin
            // final sample of the window lands straight in the output regs
            if (cnt == LAST) begin
              out_sum <= sum_nxt;
              out_avg <= 9'(sum_nxt >> LOG2N);
              acc     <= '0;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              acc   <= sum_nxt;
              cnt   <= cnt + 5'd1;
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_acc.sv
// Bench for res_acc: four instances (N=2,4,8,16) share one stimulus
// stream and are compared against a window-sum reference model.
module tb_res_acc;

  logic        clk;
  logic        rst_n;
  logic [8:0]  din;
  logic        din_vld;
  logic        clr;
  logic        out_rdy;

  logic        d_rdy [4];
  logic [12:0] d_sum [4];
  logic [8:0]  d_avg [4];
  logic        d_vld [4];
  logic [4:0]  d_cnt [4];

  int m_cnt [4];
  int m_acc [4];
  int m_sum [4];
  int m_avg [4];
  bit m_hold [4];

  int nchk = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  res_acc #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(d_rdy[0]), .clr(clr), .out_sum(d_sum[0]),
    .out_avg(d_avg[0]), .out_vld(d_vld[0]), .out_rdy(out_rdy),
    .cnt(d_cnt[0])
  );
  res_acc #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(d_rdy[1]), .clr(clr), .out_sum(d_sum[1]),
    .out_avg(d_avg[1]), .out_vld(d_vld[1]), .out_rdy(out_rdy),
    .cnt(d_cnt[1])
  );
  res_acc #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(d_rdy[2]), .clr(clr), .out_sum(d_sum[2]),
    .out_avg(d_avg[2]), .out_vld(d_vld[2]), .out_rdy(out_rdy),
    .cnt(d_cnt[2])
  );
  res_acc #(.N(16)) u16 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(d_rdy[3]), .clr(clr), .out_sum(d_sum[3]),
    .out_avg(d_avg[3]), .out_vld(d_vld[3]), .out_rdy(out_rdy),
    .cnt(d_cnt[3])
  );

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; m_acc[k] = 0; m_sum[k] = 0;
      m_avg[k] = 0; m_hold[k] = 0;
    end
  endtask

  // drive one cycle; the model sees the same pre-edge inputs
  task automatic cycle(input logic [8:0] d, input logic v,
                       input logic c, input logic r);
    din = d; din_vld = v; clr = c; out_rdy = r;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 2 << k;
      if (m_hold[k]) begin
        if (r) m_hold[k] = 0;
      end else if (c) begin
        m_cnt[k] = 0; m_acc[k] = 0;
      end else if (v) begin
        m_acc[k] += int'(d);
        m_cnt[k]++;
        if (m_cnt[k] == n) begin
          m_sum[k] = m_acc[k];
          m_avg[k] = m_acc[k] / n;
          m_acc[k] = 0; m_cnt[k] = 0; m_hold[k] = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic flush();
    cycle(9'd0, 1'b0, 1'b0, 1'b1);
    cycle(9'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; din_vld = 0; clr = 0; out_rdy = 0;
    model_reset();
    #2;
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (d_vld[k] !== 1'b0 || d_sum[k] !== 13'd0 ||
          d_avg[k] !== 9'd0 || d_cnt[k] !== 5'd0 ||
          d_rdy[k] !== 1'b1) begin
        $display("FAIL reset k=%0d vld=%b sum=%0d avg=%0d cnt=%0d rdy=%b exp 0/0/0/0/1",
                 k, d_vld[k], d_sum[k], d_avg[k], d_cnt[k], d_rdy[k]);
        nerr++;
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 8; i++) cycle(9'(i), 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_vld[2] !== 1'b1 || d_sum[2] !== 13'd36 || d_avg[2] !== 9'd4) begin
      $display("FAIL basic_out vld=%b sum=%0d avg=%0d exp 1/36/4",
               d_vld[2], d_sum[2], d_avg[2]);
      nerr++;
    end
    cycle(9'd0, 1'b0, 1'b0, 1'b1);
    nchk++;
    if (d_vld[2] !== 1'b0 || d_sum[2] !== 13'd36) begin
      $display("FAIL basic_drop vld=%b sum=%0d exp 0/36",
               d_vld[2], d_sum[2]);
      nerr++;
    end
  endtask

  task automatic test_max();
    flush();
    for (int i = 0; i < 16; i++) cycle(9'd511, 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_vld[3] !== 1'b1 || d_sum[3] !== 13'd8176 || d_avg[3] !== 9'd511) begin
      $display("FAIL max vld=%b sum=%0d avg=%0d exp 1/8176/511",
               d_vld[3], d_sum[3], d_avg[3]);
      nerr++;
    end
  endtask

  task automatic test_backpressure();
    flush();
    for (int i = 0; i < 6; i++) cycle(9'd10, 1'b1, 1'b0, 1'b0);
    nchk++;
    if (d_vld[1] !== 1'b1 || d_sum[1] !== 13'd40 ||
        d_rdy[1] !== 1'b0 || d_cnt[1] !== 5'd0) begin
      $display("FAIL bp_hold vld=%b sum=%0d rdy=%b cnt=%0d exp 1/40/0/0",
               d_vld[1], d_sum[1], d_rdy[1], d_cnt[1]);
      nerr++;
    end
    cycle(9'd0, 1'b0, 1'b0, 1'b1);
    nchk++;
    if (d_vld[1] !== 1'b0 || d_rdy[1] !== 1'b1 || d_sum[1] !== 13'd40) begin
      $display("FAIL bp_release vld=%b rdy=%b sum=%0d exp 0/1/40",
               d_vld[1], d_rdy[1], d_sum[1]);
      nerr++;
    end
    cycle(9'd10, 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_cnt[1] !== 5'd1) begin
      $display("FAIL bp_restart cnt=%0d exp 1", d_cnt[1]);
      nerr++;
    end
  endtask

  task automatic test_clear();
    flush();
    for (int i = 0; i < 3; i++) cycle(9'd100, 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_cnt[2] !== 5'd3) begin
      $display("FAIL clr_pre cnt=%0d exp 3", d_cnt[2]);
      nerr++;
    end
    cycle(9'd50, 1'b1, 1'b1, 1'b1);
    nchk++;
    if (d_cnt[2] !== 5'd0 || d_rdy[2] !== 1'b1) begin
      $display("FAIL clr_drop cnt=%0d rdy=%b exp 0/1", d_cnt[2], d_rdy[2]);
      nerr++;
    end
    for (int i = 0; i < 8; i++) cycle(9'd2, 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_vld[2] !== 1'b1 || d_sum[2] !== 13'd16 || d_avg[2] !== 9'd2) begin
      $display("FAIL clr_fresh vld=%b sum=%0d avg=%0d exp 1/16/2",
               d_vld[2], d_sum[2], d_avg[2]);
      nerr++;
    end
  endtask

  task automatic test_gap_reset();
    flush();
    cycle(9'd5, 1'b1, 1'b0, 1'b1);
    cycle(9'd0, 1'b0, 1'b0, 1'b1);
    cycle(9'd7, 1'b1, 1'b0, 1'b1);
    cycle(9'd0, 1'b0, 1'b0, 1'b1);
    cycle(9'd9, 1'b1, 1'b0, 1'b1);
    cycle(9'd3, 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_vld[1] !== 1'b1 || d_sum[1] !== 13'd24 || d_avg[1] !== 9'd6) begin
      $display("FAIL gap vld=%b sum=%0d avg=%0d exp 1/24/6",
               d_vld[1], d_sum[1], d_avg[1]);
      nerr++;
    end
    cycle(9'd4, 1'b1, 1'b0, 1'b1);
    cycle(9'd4, 1'b1, 1'b0, 1'b1);
    cycle(9'd4, 1'b1, 1'b0, 1'b1);
    nchk++;
    if (d_cnt[1] !== 5'd2) begin
      $display("FAIL gap_mid cnt=%0d exp 2", d_cnt[1]);
      nerr++;
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (d_vld[k] !== 1'b0 || d_sum[k] !== 13'd0 ||
          d_avg[k] !== 9'd0 || d_cnt[k] !== 5'd0 || d_rdy[k] !== 1'b1) begin
        $display("FAIL async_rst k=%0d vld=%b sum=%0d avg=%0d cnt=%0d rdy=%b exp 0/0/0/0/1",
                 k, d_vld[k], d_sum[k], d_avg[k], d_cnt[k], d_rdy[k]);
        nerr++;
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_clr_hold();
    for (int i = 0; i < 4; i++) cycle(9'd20 + 9'(i), 1'b1, 1'b0, 1'b0);
    cycle(9'd0, 1'b0, 1'b1, 1'b0);
    nchk++;
    if (d_vld[1] !== 1'b1 || d_sum[1] !== 13'd86 || d_avg[1] !== 9'd21) begin
      $display("FAIL clr_hold vld=%b sum=%0d avg=%0d exp 1/86/21",
               d_vld[1], d_sum[1], d_avg[1]);
      nerr++;
    end
    flush();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(9'($urandom_range(0, 511)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 4; k++) begin
        nchk++;
        if (d_vld[k] !== 1'(m_hold[k]) || d_rdy[k] !== 1'(!m_hold[k]) ||
            d_sum[k] !== 13'(m_sum[k]) || d_avg[k] !== 9'(m_avg[k]) ||
            d_cnt[k] !== 5'(m_cnt[k])) begin
          $display("FAIL rnd i=%0d N=%0d vld=%b rdy=%b sum=%0d avg=%0d cnt=%0d exp %b/%b/%0d/%0d/%0d",
                   i, 2 << k, d_vld[k], d_rdy[k], d_sum[k], d_avg[k],
                   d_cnt[k], m_hold[k], !m_hold[k], m_sum[k], m_avg[k],
                   m_cnt[k]);
          nerr++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_clear();
    test_gap_reset();
    test_clr_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
